// File: rtl/virtio_available_ring_notify_scheduler.sv
// -----------------------------------------------------------------------------
// virtio_available_ring_notify_scheduler
//
// Turns per-virtqueue doorbell pulses into single-beat AXI4-Stream
// notifications for the available ring handler. Repeated doorbells to a queue
// collapse into one pending bit. Eligible queues are served round-robin. Each
// queue may have at most one notification in flight, and a global cap limits
// the total number in flight. The handler reports completions on done_*.
//
// Optional build macro:
//   VIRTIO_AVAILABLE_RING_NOTIFY_SCHEDULER_COALESCE_COUNT_EN
//     defined   : coalesced_count is a 16-bit saturating count of the cycles
//                 in which a live doorbell hit an already-pending queue
//     undefined : coalesced_count is tied to 0
//
// Ports:
//   aclk, areset     clock and synchronous active-high reset
//   doorbell         per-queue one-cycle doorbell pulses
//   queue_enable     per-queue live/configured level
//   notify_t*        AXI4-Stream notify channel (tdata = queue index)
//   done_valid/queue completion of one notification from the handler
//   pending          registered pending bitmap
//   in_flight        registered in-flight bitmap
//   outstanding      number of notifications issued and not yet completed
//   coalesced_count  see optional build macro above
// -----------------------------------------------------------------------------
module virtio_available_ring_notify_scheduler #(
  parameter int QUEUES          = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [QUEUES-1:0]                  doorbell,
  input  logic [QUEUES-1:0]                  queue_enable,
  output logic                               notify_tvalid,
  input  logic                               notify_tready,
  output logic [7:0]                         notify_tdata,
  output logic                               notify_tlast,
  input  logic                               done_valid,
  input  logic [7:0]                         done_queue,
  output logic [QUEUES-1:0]                  pending,
  output logic [QUEUES-1:0]                  in_flight,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic [15:0]                        coalesced_count
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t      state;
  logic [7:0]  rr_ptr;

  logic [QUEUES-1:0] eligible;
  logic [QUEUES-1:0] db_hit;
  logic [QUEUES-1:0] grant_onehot;
  logic [QUEUES-1:0] done_onehot;
  logic [QUEUES-1:0] pending_nxt;
  logic [QUEUES-1:0] in_flight_nxt;
  logic [OW-1:0]     outstanding_nxt;
  logic              handshake;
  logic              done_ok;
  logic              cap_ok;
  logic              cap_b2b_ok;
  logic              idle_found;
  logic              b2b_found;
  logic [7:0]        idle_pick;
  logic [7:0]        b2b_pick;
  logic [7:0]        next_ptr;
  logic [8:0]        ptr_sum;

  // Round-robin search: first set bit of req at or above start, wrapping at
  // QUEUES-1. Returns {found, index}.
  function automatic logic [8:0] rr_pick(input logic [QUEUES-1:0] req,
                                         input logic [7:0]        start);
    logic       found;
    logic [7:0] pick;
    int         idx;
    found = 1'b0;
    pick  = 8'd0;
    for (int i = 0; i < QUEUES; i++) begin
      idx = int'(start) + i;
      if (idx >= QUEUES) idx = idx - QUEUES;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = 8'(idx);
      end
    end
    return {found, pick};
  endfunction

  assign notify_tlast = notify_tvalid;
  assign handshake    = notify_tvalid && notify_tready;
  assign db_hit       = doorbell & queue_enable;
  assign eligible     = pending & ~in_flight & queue_enable;
  assign cap_ok       = int'(outstanding) < MAX_OUTSTANDING;
  // Back-to-back reload must leave room for the beat that is completing now.
  assign cap_b2b_ok   = (int'(outstanding) + 1) < MAX_OUTSTANDING;

  // Pointer after a grant: granted + 1, wrapping to 0 at QUEUES.
  assign ptr_sum  = {1'b0, notify_tdata} + 9'd1;
  assign next_ptr = (ptr_sum >= 9'(QUEUES)) ? 8'd0 : ptr_sum[7:0];

  // Decoding by comparison keeps out-of-range done_queue values harmless:
  // they simply match no bit.
  always_comb begin
    grant_onehot = '0;
    done_onehot  = '0;
    for (int q = 0; q < QUEUES; q++) begin
      grant_onehot[q] = handshake && (notify_tdata == 8'(q));
      done_onehot[q]  = done_valid && (done_queue == 8'(q)) && in_flight[q];
    end
  end

  assign done_ok = |done_onehot;

  always_comb begin
    {idle_found, idle_pick} = rr_pick(eligible, rr_ptr);
    {b2b_found,  b2b_pick}  = rr_pick(eligible & ~grant_onehot, next_ptr);
  end

  // A new doorbell wins over a same-cycle grant; disabling a queue always
  // drops its pending bit.
  assign pending_nxt   = ((pending & ~grant_onehot) | db_hit) & queue_enable;
  // A queue being granted cannot also complete: grant needs in_flight = 0,
  // completion needs in_flight = 1.
  assign in_flight_nxt = (in_flight | grant_onehot) & ~done_onehot;

  always_comb begin
    outstanding_nxt = outstanding;
    case ({handshake, done_ok})
      2'b10:   outstanding_nxt = outstanding + OW'(1);
      2'b01:   outstanding_nxt = outstanding - OW'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= IDLE;
      notify_tvalid <= 1'b0;
      notify_tdata  <= 8'd0;
      rr_ptr        <= 8'd0;
      pending       <= '0;
      in_flight     <= '0;
      outstanding   <= '0;
    end else begin
      pending     <= pending_nxt;
      in_flight   <= in_flight_nxt;
      outstanding <= outstanding_nxt;
      case (state)
        IDLE: begin
          if (idle_found && cap_ok) begin
            notify_tvalid <= 1'b1;
            notify_tdata  <= idle_pick;
            state         <= OFFER;
          end
        end
        OFFER: begin
          // The offer is held unchanged until accepted, even if the queue
          // is disabled meanwhile.
          if (handshake) begin
            rr_ptr <= next_ptr;
            if (b2b_found && cap_b2b_ok) begin
              notify_tdata <= b2b_pick;
            end else begin
              notify_tvalid <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: begin
          notify_tvalid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef VIRTIO_AVAILABLE_RING_NOTIFY_SCHEDULER_COALESCE_COUNT_EN
  logic coalesce_hit;

  assign coalesce_hit = |(db_hit & pending);

  always_ff @(posedge aclk) begin
    if (areset) begin
      coalesced_count <= 16'd0;
    end else if (coalesce_hit && (coalesced_count != 16'hFFFF)) begin
      coalesced_count <= coalesced_count + 16'd1;
    end
  end
`else
  assign coalesced_count = 16'd0;
`endif

endmodule

// File: tb/tb_virtio_available_ring_notify_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for virtio_available_ring_notify_scheduler (QUEUES=8,
// MAX_OUTSTANDING=4). Directed stimulus pushes the expected notify queue
// indices into a scoreboard; a monitor on the falling edge pops and compares
// on every notify handshake. Bitmaps and counters are checked directly.
// -----------------------------------------------------------------------------
module tb_virtio_available_ring_notify_scheduler;

  localparam int QUEUES = 8;
  localparam int MAXO   = 4;
  localparam int OW     = $clog2(MAXO + 1);

  logic              aclk = 1'b0;
  logic              areset;
  logic [QUEUES-1:0] doorbell;
  logic [QUEUES-1:0] queue_enable;
  logic              notify_tvalid;
  logic              notify_tready;
  logic [7:0]        notify_tdata;
  logic              notify_tlast;
  logic              done_valid;
  logic [7:0]        done_queue;
  logic [QUEUES-1:0] pending;
  logic [QUEUES-1:0] in_flight;
  logic [OW-1:0]     outstanding;
  logic [15:0]       coalesced_count;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb[$];
  logic [7:0] mon_exp;

`ifdef VIRTIO_AVAILABLE_RING_NOTIFY_SCHEDULER_COALESCE_COUNT_EN
  localparam logic [15:0] EXP_COALESCE = 16'd2;
`else
  localparam logic [15:0] EXP_COALESCE = 16'd0;
`endif

  virtio_available_ring_notify_scheduler #(
    .QUEUES(QUEUES),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .doorbell(doorbell),
    .queue_enable(queue_enable),
    .notify_tvalid(notify_tvalid),
    .notify_tready(notify_tready),
    .notify_tdata(notify_tdata),
    .notify_tlast(notify_tlast),
    .done_valid(done_valid),
    .done_queue(done_queue),
    .pending(pending),
    .in_flight(in_flight),
    .outstanding(outstanding),
    .coalesced_count(coalesced_count)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset     = 1'b1;
    doorbell   = '0;
    done_valid = 1'b0;
    done_queue = 8'd0;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic do_done(input logic [7:0] q);
    done_valid = 1'b1;
    done_queue = q;
    tick();
    done_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (notify_tvalid) break;
      tick();
    end
    check(name, notify_tvalid, 1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !notify_tvalid) break;
      tick();
    end
    check(name, {sb.size() == 0, notify_tvalid}, 2'b10);
  endtask

  // Scoreboard monitor: one comparison per accepted beat.
  always @(negedge aclk) begin
    if (!areset && notify_tvalid && notify_tready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat actual_tdata=%0d expected=none", notify_tdata);
      end else begin
        mon_exp = sb.pop_front();
        if (notify_tdata !== mon_exp || notify_tlast !== 1'b1) begin
          failures++;
          $display("FAIL beat actual_tdata=%0d tlast=%0b expected_tdata=%0d tlast=1",
                   notify_tdata, notify_tlast, mon_exp);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    areset        = 1'b1;
    doorbell      = '0;
    queue_enable  = '1;
    notify_tready = 1'b1;
    done_valid    = 1'b0;
    done_queue    = 8'd0;

    // Reset state and single-queue latency
    do_reset();
    check("rst_pending", pending, 0);
    check("rst_in_flight", in_flight, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_tvalid", notify_tvalid, 0);
    check("rst_tdata", notify_tdata, 0);
    check("rst_coalesced", coalesced_count, 0);
    doorbell = 8'h08;
    sb.push_back(8'd3);
    tick();
    doorbell = '0;
    check("lat_pending", pending, 8'h08);
    check("lat_tvalid_early", notify_tvalid, 0);
    tick();
    check("lat_tvalid", notify_tvalid, 1);
    check("lat_tdata", notify_tdata, 3);
    check("lat_tlast", notify_tlast, 1);
    tick();
    check("lat_in_flight", in_flight, 8'h08);
    check("lat_outstanding", outstanding, 1);
    check("lat_tvalid_after", notify_tvalid, 0);
    do_done(8'd3);
    check("done_in_flight", in_flight, 0);
    check("done_outstanding", outstanding, 0);

    // Round-robin, back-to-back and wrap
    do_reset();
    doorbell = 8'h62;
    sb.push_back(8'd1);
    sb.push_back(8'd5);
    sb.push_back(8'd6);
    tick();
    doorbell = '0;
    check("rr_pending", pending, 8'h62);
    tick();
    check("rr_first", notify_tdata, 1);
    tick();
    check("rr_second", {notify_tvalid, notify_tdata}, {1'b1, 8'd5});
    tick();
    check("rr_third", {notify_tvalid, notify_tdata}, {1'b1, 8'd6});
    tick();
    check("rr_idle", notify_tvalid, 0);
    check("rr_in_flight", in_flight, 8'h62);
    check("rr_outstanding", outstanding, 3);
    do_done(8'd1);
    do_done(8'd5);
    do_done(8'd6);
    check("rr_outstanding0", outstanding, 0);
    doorbell = 8'h05;
    sb.push_back(8'd0);
    sb.push_back(8'd2);
    tick();
    doorbell = '0;
    wait_drain("rr_wrap_drain", 10);
    check("rr_wrap_in_flight", in_flight, 8'h05);
    do_done(8'd0);
    do_done(8'd2);
    // pointer is now 3: queue 4 ahead of queue 1
    doorbell = 8'h12;
    sb.push_back(8'd4);
    sb.push_back(8'd1);
    tick();
    doorbell = '0;
    wait_drain("rr_ptr_drain", 10);
    do_done(8'd4);
    do_done(8'd1);

    // Global in-flight cap
    do_reset();
    doorbell = 8'h3F;
    sb.push_back(8'd0);
    sb.push_back(8'd1);
    sb.push_back(8'd2);
    sb.push_back(8'd3);
    tick();
    doorbell = '0;
    repeat (8) tick();
    check("cap_tvalid", notify_tvalid, 0);
    check("cap_outstanding", outstanding, 4);
    check("cap_in_flight", in_flight, 8'h0F);
    check("cap_pending", pending, 8'h30);
    check("cap_sb_empty", sb.size(), 0);
    sb.push_back(8'd4);
    do_done(8'd0);
    wait_drain("cap_reissue_drain", 10);
    check("cap_reissue_in_flight", in_flight, 8'h1E);
    check("cap_reissue_pending", pending, 8'h20);
    check("cap_reissue_outstanding", outstanding, 4);

    // Stall with disable during the offer
    do_reset();
    notify_tready = 1'b0;
    doorbell = 8'h10;
    tick();
    doorbell = '0;
    sb.push_back(8'd4);
    wait_valid("stall_valid", 5);
    for (int k = 0; k < 10; k++) begin
      if (k == 3) queue_enable[4] = 1'b0;
      tick();
      check("stall_hold", {notify_tvalid, notify_tdata}, {1'b1, 8'd4});
    end
    check("stall_pending_dropped", pending[4], 0);
    notify_tready = 1'b1;
    tick();
    check("stall_hs_in_flight", in_flight, 8'h10);
    check("stall_hs_pending", pending, 0);
    check("stall_hs_tvalid", notify_tvalid, 0);
    queue_enable = '1;
    do_done(8'd4);

    // Coalescing while in flight
    do_reset();
    doorbell = 8'h04;
    sb.push_back(8'd2);
    tick();
    doorbell = '0;
    wait_drain("coal_first_drain", 10);
    check("coal_in_flight", in_flight, 8'h04);
    for (int k = 0; k < 3; k++) begin
      doorbell = 8'h04;
      tick();
      doorbell = '0;
      tick();
    end
    check("coal_pending", pending, 8'h04);
    repeat (3) tick();
    check("coal_blocked", notify_tvalid, 0);
    check("coal_count", coalesced_count, EXP_COALESCE);
    sb.push_back(8'd2);
    do_done(8'd2);
    wait_drain("coal_renotify_drain", 10);
    repeat (4) tick();
    check("coal_single_renotify", {notify_tvalid, pending}, {1'b0, 8'h00});
    check("coal_outstanding", outstanding, 1);

    // Ignored completions
    do_done(8'd9);
    check("bad_done9_in_flight", in_flight, 8'h04);
    check("bad_done9_outstanding", outstanding, 1);
    do_done(8'd5);
    check("bad_done5_in_flight", in_flight, 8'h04);
    check("bad_done5_outstanding", outstanding, 1);

    // Reset during an offer
    notify_tready = 1'b0;
    doorbell = 8'h40;
    tick();
    doorbell = '0;
    wait_valid("rst_offer_valid", 5);
    areset = 1'b1;
    tick();
    check("rst_offer_tvalid", notify_tvalid, 0);
    check("rst_offer_pending", pending, 0);
    check("rst_offer_in_flight", in_flight, 0);
    check("rst_offer_outstanding", outstanding, 0);
    check("rst_offer_coalesced", coalesced_count, 0);
    areset = 1'b0;
    notify_tready = 1'b1;
    repeat (4) tick();
    check("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
